// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX sequencer.
// The CRC16 constants are only consumed when USB_TX_CRC16_EN is defined.
package usb_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC, ST_STUFF_TAIL, ST_EOP1, ST_EOP2, ST_EOP_J
  } tx_state_t;

  localparam logic [2:0] SV_IDLE       = 3'd0;
  localparam logic [2:0] SV_SYNC       = 3'd1;
  localparam logic [2:0] SV_PID        = 3'd2;
  localparam logic [2:0] SV_DATA       = 3'd3;
  localparam logic [2:0] SV_CRC        = 3'd4;
  localparam logic [2:0] SV_STUFF_TAIL = 3'd5;
  localparam logic [2:0] SV_EOP1       = 3'd6;
  localparam logic [2:0] SV_EOP2       = 3'd7;

  localparam logic [7:0]  SYNC_BYTE      = 8'h80;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam int          STUFF_LIMIT    = 6;

  function automatic logic [2:0] state_val_of(input tx_state_t s);
    case (s)
      ST_SYNC:       return SV_SYNC;
      ST_PID:        return SV_PID;
      ST_DATA:       return SV_DATA;
      ST_CRC:        return SV_CRC;
      ST_STUFF_TAIL: return SV_STUFF_TAIL;
      ST_EOP1:       return SV_EOP1;
      ST_EOP2:       return SV_EOP2;
      default:       return SV_IDLE; // IDLE and EOP_J both hold J
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_controller_crc16.sv
// Serial USB CRC16 (x^16+x^15+x^2+1), one payload bit per enable, LSB-first data order.
module usb_crc16 import usb_tx_pkg::*; (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);
  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    fb    = bit_in ^ crc_q[15];
    crc_d = crc_q;
    if (clear)       crc_d = CRC16_INIT;
    else if (enable) crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) crc_q <= CRC16_INIT;
    else        crc_q <= crc_d;

  assign crc = crc_q;
endmodule

// File: rtl/usb_tx_controller.sv
// USB packet sequencer feeding the NRZI encoder: SYNC, PID, payload, optional CRC16, EOP, bit stuffing.
// Optional CRC16 on data PIDs is enabled by defining USB_TX_CRC16_EN.
module usb_tx_controller import usb_tx_pkg::*; #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_has_data,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_data_last,
  output logic       tx_data_ready,
  output logic       serial_in,
  output logic       encoder_in,
  output logic [2:0] state_val,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int            TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q, state_d, after_payload;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d, ones_q, ones_d;
  logic [7:0]    byte_q, byte_d;
  logic [3:0]    pid_q, pid_d;
  logic          has_data_q, has_data_d, last_q, last_d, stuff_q, stuff_d;
  logic          tick, first, bit_state, cur_bit, eob, to_eop, adv, fetch;

  assign tick      = (timer_q == T_LAST);
  assign first     = (timer_q == '0) && (state_q != ST_IDLE);
  assign eob       = (bit_idx_q == 3'd7);
  assign bit_state = (state_q == ST_SYNC) || (state_q == ST_PID) ||
                     (state_q == ST_DATA) || (state_q == ST_CRC);

`ifdef USB_TX_CRC16_EN
  logic        crc_byte_q, crc_byte_d;
  logic [15:0] crc;
  usb_crc16 u_crc (
    .clk(clk), .n_rst(n_rst),
    .clear(state_q == ST_IDLE && tx_start),
    .enable(state_q == ST_DATA && tick && !stuff_q),
    .bit_in(cur_bit), .crc(crc)
  );
  assign after_payload = (pid_q[1:0] == 2'b11) ? ST_CRC : ST_EOP1;
  // Inverted CRC leaves MSb of the shift register first (bit-reflected LSB on the wire).
  always_comb begin
    cur_bit = byte_q[bit_idx_q];
    if (state_q == ST_CRC) cur_bit = ~crc[4'd15 - {crc_byte_q, bit_idx_q}];
  end
`else
  assign after_payload = ST_EOP1;
  assign cur_bit       = byte_q[bit_idx_q];
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;  timer_q  <= '0;   bit_idx_q  <= '0;   ones_q  <= '0;
      byte_q  <= '0;       pid_q    <= '0;   has_data_q <= 1'b0; last_q  <= 1'b0;
      stuff_q <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_byte_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  timer_q  <= timer_d; bit_idx_q  <= bit_idx_d;  ones_q <= ones_d;
      byte_q  <= byte_d;   pid_q    <= pid_d;   has_data_q <= has_data_d; last_q <= last_d;
      stuff_q <= stuff_d;
`ifdef USB_TX_CRC16_EN
      crc_byte_q <= crc_byte_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q; timer_d = timer_q; bit_idx_d = bit_idx_q; ones_d = ones_q;
    byte_d = byte_q; pid_d = pid_q; has_data_d = has_data_q; last_d = last_q;
    stuff_d = stuff_q; adv = 1'b0; fetch = 1'b0; to_eop = 1'b0;
`ifdef USB_TX_CRC16_EN
    crc_byte_d = crc_byte_q;
`endif
    if (state_q != ST_IDLE) timer_d = tick ? '0 : timer_q + 1'b1;
    case (state_q)
      ST_IDLE: if (tx_start) begin
        state_d = ST_SYNC; timer_d = '0; bit_idx_d = '0; ones_d = '0; stuff_d = 1'b0;
        byte_d = SYNC_BYTE; pid_d = tx_pid; has_data_d = tx_has_data; last_d = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_byte_d = 1'b0;
`endif
      end
      ST_STUFF_TAIL: if (tick) state_d = ST_EOP1;
      ST_EOP1:       if (tick) state_d = ST_EOP2;
      ST_EOP2:       if (tick) state_d = ST_EOP_J;
      ST_EOP_J:      if (tick) state_d = ST_IDLE;
      default: if (tick) begin
        case (state_q)
          ST_PID:  to_eop = eob && !has_data_q && (after_payload == ST_EOP1);
          ST_DATA: to_eop = eob && last_q && (after_payload == ST_EOP1);
`ifdef USB_TX_CRC16_EN
          ST_CRC:  to_eop = eob && crc_byte_q;
`endif
          default: to_eop = 1'b0;
        endcase
        // A stuffed period replays the advance that the 6th one postponed.
        if (stuff_q)       begin stuff_d = 1'b0; ones_d = '0; adv = 1'b1; end
        else if (!cur_bit) begin ones_d = '0; adv = 1'b1; end
        else if (ones_q == 3'(STUFF_LIMIT - 1)) begin
          ones_d = '0;
          if (to_eop) state_d = ST_STUFF_TAIL;
          else        stuff_d = 1'b1;
        end
        else begin ones_d = ones_q + 3'd1; adv = 1'b1; end

        if (adv) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (eob) begin
            case (state_q)
              ST_SYNC: begin state_d = ST_PID; byte_d = {~pid_q, pid_q}; end
              ST_PID:  if (has_data_q) fetch = 1'b1; else state_d = after_payload;
              ST_DATA: if (!last_q)    fetch = 1'b1; else state_d = after_payload;
`ifdef USB_TX_CRC16_EN
              ST_CRC:  if (crc_byte_q) state_d = ST_EOP1; else crc_byte_d = 1'b1;
`endif
              default: state_d = ST_EOP1;
            endcase
            if (fetch) begin
              if (tx_data_valid) begin
                state_d = ST_DATA; byte_d = tx_data; last_d = tx_data_last;
              end else begin
                state_d = ST_EOP1;
              end
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    serial_in     = 1'b1;
    encoder_in    = 1'b0;
    state_val     = state_val_of(state_q);
    tx_busy       = (state_q != ST_IDLE);
    tx_done       = (state_q == ST_EOP_J) && tick;
    tx_data_ready = fetch && tx_data_valid;
    tx_error      = fetch && !tx_data_valid;
    if (first) begin
      if (stuff_q || state_q == ST_STUFF_TAIL) encoder_in = 1'b1;
      else if (bit_state)                      serial_in  = cur_bit;
    end
  end
endmodule

// File: tb/tb_usb_tx_controller.sv
// Self-checking bench for usb_tx_controller: directed table, corner sequences, random packets vs model.
`timescale 1ns/1ps
module tb_usb_tx_controller;
  import usb_tx_pkg::*;
  localparam int C = 8;
  localparam int BUDGET = 3000;

  logic clk = 1'b0, n_rst = 1'b0, tx_start = 1'b0, tx_has_data = 1'b0;
  logic tx_data_valid = 1'b0, tx_data_last = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [7:0] tx_data = 8'h00;
  logic tx_data_ready, serial_in, encoder_in, tx_busy, tx_done, tx_error;
  logic [2:0] state_val;

  always #5 clk = ~clk;

  usb_tx_controller #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_pid(tx_pid), .tx_has_data(tx_has_data),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_last(tx_data_last),
    .tx_data_ready(tx_data_ready), .serial_in(serial_in), .encoder_in(encoder_in),
    .state_val(state_val), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  int checks = 0, failures = 0;
  // symbols per bit period: 0/1 data bit, 2 stuffed bit, 3 SE0, 4 J
  int sym_q[$], exp_q[$];
  int exp_err_at, exp_ready, exp_err;
  bit exp_crc;
  int r_done_off, r_done_cnt, r_err_cnt, r_err_off, r_ready, r_hold_bad, r_busy_bad, r_busy_after;

  typedef struct {
    logic [3:0] pid; bit hd; int nb; logic [31:0] data; int avail;
    int exp_periods; int exp_ready; int exp_err; logic [7:0] exp_pidb;
  } vec_t;
  vec_t vt[8];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sym_now();
    if (state_val >= 3'd6) return 3;
    if (encoder_in)        return 2;
    if (state_val == 3'd0) return 4;
    return serial_in ? 1 : 0;
  endfunction

  task automatic feed(input int idx, input int nb, input logic [31:0] data, input int avail);
    tx_data_valid = (idx < avail) && (idx < nb);
    tx_data       = (idx < nb) ? data[idx*8 +: 8] : 8'($urandom);
    tx_data_last  = (idx == nb - 1);
  endtask

  task automatic build_model(input logic [3:0] pid, input bit hd, input int nb,
                             input logic [31:0] data, input int avail);
    bit bits[$];
    logic [7:0] pb, by;
    logic [15:0] c;
    int ndel, ones;
    bit fb;
    bits.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) bits.push_back(SYNC_BYTE[i]);
    pb = {~pid, pid};
    for (int i = 0; i < 8; i++) bits.push_back(pb[i]);
    ndel = hd ? ((avail < nb) ? avail : nb) : 0;
    exp_err = (hd && avail < nb) ? 1 : 0;
    exp_ready = ndel;
    c = 16'hFFFF;
    for (int b = 0; b < ndel; b++) begin
      by = data[b*8 +: 8];
      for (int i = 0; i < 8; i++) begin
        bits.push_back(by[i]);
        fb = by[i] ^ c[15];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    exp_crc = 1'b0;
`ifdef USB_TX_CRC16_EN
    exp_crc = (pid[1:0] == 2'b11) && !exp_err;
    if (exp_crc) for (int i = 15; i >= 0; i--) bits.push_back(~c[i]);
`endif
    ones = 0;
    foreach (bits[i]) begin
      exp_q.push_back(int'(bits[i]));
      if (bits[i]) begin
        ones++;
        if (ones == 6) begin exp_q.push_back(2); ones = 0; end
      end else ones = 0;
    end
    exp_err_at = exp_q.size();
    exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(4);
  endtask

  task automatic run_pkt(input logic [3:0] pid, input bit hd, input int nb,
                         input logic [31:0] data, input int avail, input int poke_at);
    int idx;
    bit pend, stop_nxt;
    sym_q.delete();
    r_done_off = -1; r_done_cnt = 0; r_err_cnt = 0; r_err_off = -1; r_ready = 0;
    r_hold_bad = 0; r_busy_bad = 0; r_busy_after = 1;
    idx = 0; stop_nxt = 1'b0;
    @(negedge clk);
    tx_start = 1'b1; tx_pid = pid; tx_has_data = hd;
    feed(idx, nb, data, avail);
    @(posedge clk); #1;
    tx_start = 1'b0; tx_pid = 4'($urandom); tx_has_data = 1'($urandom);
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      if (stop_nxt) begin r_busy_after = int'(tx_busy); break; end
      if (((cyc - 1) % C) == 0) sym_q.push_back(sym_now());
      else if (serial_in !== 1'b1 || encoder_in !== 1'b0) r_hold_bad++;
      if (tx_busy !== 1'b1) r_busy_bad++;
      if (tx_error) begin r_err_cnt++; r_err_off = cyc; end
      if (tx_done) begin r_done_cnt++; r_done_off = cyc; stop_nxt = 1'b1; end
      pend = tx_data_ready;
      if (pend) r_ready++;
      @(posedge clk); #1;
      tx_start = (cyc == poke_at);
      if (pend) begin idx++; feed(idx, nb, data, avail); end
    end
    tx_start = 1'b0;
  endtask

  task automatic compare_pkt(input string nm);
    int mism;
    logic [15:0] c;
    int k;
    mism = (sym_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < sym_q.size() && i < exp_q.size(); i++) if (sym_q[i] != exp_q[i]) mism++;
    check({nm, "_stream_mismatches"}, mism, 0);
    check({nm, "_done_at"}, r_done_off, exp_q.size() * C);
    check({nm, "_done_count"}, r_done_cnt, 1);
    check({nm, "_ready_pulses"}, r_ready, exp_ready);
    check({nm, "_error_pulses"}, r_err_cnt, exp_err);
    if (exp_err != 0) check({nm, "_error_at"}, r_err_off, exp_err_at * C);
    check({nm, "_hold_cycles_bad"}, r_hold_bad, 0);
    check({nm, "_busy_low_cycles"}, r_busy_bad, 0);
    check({nm, "_busy_after_done"}, r_busy_after, 0);
    if (exp_crc) begin
      c = 16'hFFFF; k = 16;
      while (k < sym_q.size() && sym_q[k] != 3) begin
        if (sym_q[k] < 2) c = {c[14:0], 1'b0} ^ (((sym_q[k] != 0) ^ c[15]) ? 16'h8005 : 16'h0000);
        k++;
      end
      check({nm, "_crc_residual"}, int'(c), int'(CRC16_RESIDUAL));
    end
  endtask

  task automatic idle_watch(input string nm, input int n);
    int b, d;
    b = 0; d = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_busy) b++;
      if (tx_done) d++;
    end
    check({nm, "_busy_when_idle"}, b, 0);
    check({nm, "_extra_done"}, d, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pidb;
    logic [3:0] rp;
    bit rhd;
    int rnb, rav;
    logic [31:0] rd;

    vt[0] = '{4'h2, 1'b0, 0, 32'h0000_0000, 0, 19, 0, 0, 8'hD2};
    vt[1] = '{4'h1, 1'b1, 2, 32'h0000_FFFF, 2, 38, 2, 0, 8'hE1};
    vt[2] = '{4'h3, 1'b1, 2, 32'h0000_FFFF, 0, 19, 0, 1, 8'hC3};
    vt[3] = '{4'h1, 1'b1, 2, 32'h0000_0000, 1, 27, 1, 1, 8'hE1};
    vt[4] = '{4'hA, 1'b0, 0, 32'h0000_0000, 0, 19, 0, 0, 8'h5A};
    vt[5] = '{4'hE, 1'b0, 0, 32'h0000_0000, 0, 19, 0, 0, 8'h1E};
    vt[6] = '{4'h1, 1'b1, 1, 32'h0000_00FC, 1, 28, 1, 0, 8'hE1};
    vt[7] = '{4'h9, 1'b0, 0, 32'h0000_0000, 0, 19, 0, 0, 8'h69};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_serial_in", int'(serial_in), 1);
    check("reset_encoder_in", int'(encoder_in), 0);
    check("reset_state_val", int'(state_val), 0);
    check("reset_busy", int'(tx_busy), 0);
    check("reset_done_error_ready", int'({tx_done, tx_error, tx_data_ready}), 0);
    n_rst = 1'b1;

    foreach (vt[i]) begin
      run_pkt(vt[i].pid, vt[i].hd, vt[i].nb, vt[i].data, vt[i].avail, 0);
      build_model(vt[i].pid, vt[i].hd, vt[i].nb, vt[i].data, vt[i].avail);
      check($sformatf("vec%0d_periods", i), sym_q.size(), vt[i].exp_periods);
      check($sformatf("vec%0d_ready", i), r_ready, vt[i].exp_ready);
      check($sformatf("vec%0d_error", i), r_err_cnt, vt[i].exp_err);
      check($sformatf("vec%0d_done_at", i), r_done_off, vt[i].exp_periods * C);
      pidb = 8'h00;
      for (int b = 0; b < 8; b++) if (sym_q.size() > 8 + b) pidb[b] = (sym_q[8 + b] == 1);
      check($sformatf("vec%0d_pid_byte", i), int'(pidb), int'(vt[i].exp_pidb));
      if (vt[i].exp_err != 0) check($sformatf("vec%0d_error_at", i), r_err_off, (vt[i].exp_periods - 3) * C);
      compare_pkt($sformatf("vec%0d", i));
    end

    // DATA0 with FF,FF: stuffing across SYNC/PID/payload boundaries
    run_pkt(4'h3, 1'b1, 2, 32'h0000_FFFF, 2, 0);
    build_model(4'h3, 1'b1, 2, 32'h0000_FFFF, 2);
    compare_pkt("data0_ffff");

    // tx_start pulsed mid-packet must be ignored
    run_pkt(4'h1, 1'b1, 2, 32'h0000_A5FF, 2, 30);
    build_model(4'h1, 1'b1, 2, 32'h0000_A5FF, 2);
    compare_pkt("start_while_busy");
    idle_watch("start_while_busy", 4 * C);

    // asynchronous reset in the middle of the payload
    @(negedge clk);
    tx_start = 1'b1; tx_pid = 4'h1; tx_has_data = 1'b1;
    tx_data = 8'h55; tx_data_valid = 1'b1; tx_data_last = 1'b0;
    @(posedge clk); #1 tx_start = 1'b0;
    repeat (20 * C) @(posedge clk);
    @(negedge clk);
    check("midrst_was_in_data", int'(state_val), int'(SV_DATA));
    n_rst = 1'b0; #1;
    check("midrst_serial_in", int'(serial_in), 1);
    check("midrst_encoder_in", int'(encoder_in), 0);
    check("midrst_state_val", int'(state_val), 0);
    check("midrst_busy", int'(tx_busy), 0);
    check("midrst_done_error_ready", int'({tx_done, tx_error, tx_data_ready}), 0);
    @(negedge clk);
    n_rst = 1'b1; tx_data_valid = 1'b0;
    run_pkt(4'h2, 1'b0, 0, 32'h0, 0, 0);
    build_model(4'h2, 1'b0, 0, 32'h0, 0);
    compare_pkt("ack_after_reset");

`ifdef USB_TX_CRC16_EN
    run_pkt(4'h3, 1'b0, 0, 32'h0, 0, 0);
    build_model(4'h3, 1'b0, 0, 32'h0, 0);
    compare_pkt("crc_empty");
    rnb = 0;
    for (int i = 16; i < 32 && i < sym_q.size(); i++) if (sym_q[i] != 0) rnb++;
    check("crc_empty_zero_bytes", rnb, 0);
    run_pkt(4'h3, 1'b1, 4, 32'h0302_0100, 4, 0);
    build_model(4'h3, 1'b1, 4, 32'h0302_0100, 4);
    compare_pkt("crc_00010203");
`endif

    for (int n = 0; n < 40; n++) begin
      rp  = 4'($urandom_range(0, 15));
      rhd = 1'($urandom_range(0, 1));
      rnb = rhd ? $urandom_range(1, 4) : 0;
      for (int b = 0; b < 4; b++) rd[b*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      rav = (rhd && $urandom_range(0, 4) == 0) ? $urandom_range(0, rnb - 1) : rnb;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_pkt(rp, rhd, rnb, rd, rav, 0);
      build_model(rp, rhd, rnb, rd, rav);
      compare_pkt($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
